pipeline_ctrl: RTL and testbench

Sequencing controller for the 3-stage core (IF, EX, WB). It owns the EX and WB slot valid bits, selects the next-PC source, and generates stage enables. It handles boot bubbles, taken-branch/jump redirect bubbles and memory-stall freezes. Its wb_valid output gates register-file writes and drives is_wb into the EX forwarding logic, so a killed or bubble instruction is never forwarded.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/pipe_perf_counter.sv | 31 +++
 rtl/pipeline_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the 3-stage core sequencing controller.
// Next-PC select values and controller FSM states.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_SEL_PLUS4 = 2'd0,
        PC_SEL_ALU   = 2'd1,
        PC_SEL_RESET = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        CTRL_BOOT  = 2'd0,
        CTRL_RUN   = 2'd1,
        CTRL_STALL = 2'd2
    } ctrl_state_e;

    localparam int unsigned BOOT_CNT_W  = 4;
    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned PERF_CNT_W  = 32;

endpackage

// File: rtl/pipe_perf_counter.sv
// Free-running 32-bit event counter with count enable; wraps at 2^32.
module pipe_perf_counter
    import pipeline_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [PERF_CNT_W-1:0] count
);

    logic [PERF_CNT_W-1:0] count_q;
    logic [PERF_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// IF/EX/WB sequencing controller: slot valid bits, next-PC select, stage enables,
// redirect bubbles, stall freeze and stall watchdog. Optional PIPE_PERF_CNT_EN adds perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_BUBBLES  = 1,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_redirect,
    input  logic        mem_stall,
    output logic [1:0]  pc_sel,
    output logic        pc_en,
    output logic        ex_en,
    output logic        wb_en,
    output logic        ex_valid,
    output logic        wb_valid,
    output logic        redirect_fire,
    output logic        stall_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [BOOT_CNT_W-1:0]  BOOT_LAST   = BOOT_CNT_W'(BOOT_BUBBLES - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(STALL_TIMEOUT);

    ctrl_state_e            state_q, state_d;
    logic [BOOT_CNT_W-1:0]  boot_cnt_q, boot_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   ex_valid_q, ex_valid_d;
    logic                   wb_valid_q, wb_valid_d;
    logic                   stall_err_q, stall_err_d;

    pc_sel_e                pc_sel_s;
    logic                   freeze;
    logic                   fire;

    // State register (FSM plus valid bits and watchdog)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CTRL_BOOT;
            boot_cnt_q  <= '0;
            stall_cnt_q <= '0;
            ex_valid_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            ex_valid_q  <= ex_valid_d;
            wb_valid_q  <= wb_valid_d;
            stall_err_q <= stall_err_d;
        end
    end

    // Output decode: freeze is combinational from mem_stall outside BOOT
    always_comb begin
        pc_sel_s = PC_SEL_PLUS4;
        freeze   = 1'b0;
        fire     = 1'b0;
        unique case (state_q)
            CTRL_RUN, CTRL_STALL: begin
                if (mem_stall) begin
                    freeze = 1'b1;
                end else begin
                    fire = ex_valid_q & ex_redirect;
                    if (fire) begin
                        pc_sel_s = PC_SEL_ALU;
                    end
                end
            end
            default: begin
                if (boot_cnt_q == '0) begin
                    pc_sel_s = PC_SEL_RESET;
                end
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        stall_cnt_d = stall_cnt_q;
        ex_valid_d  = ex_valid_q;
        wb_valid_d  = wb_valid_q;
        unique case (state_q)
            CTRL_RUN, CTRL_STALL: begin
                if (freeze) begin
                    state_d = CTRL_STALL;
                    if (state_q == CTRL_RUN) begin
                        stall_cnt_d = STALL_CNT_W'(1);
                    end else if (stall_cnt_q != STALL_LIMIT) begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end else begin
                    // The fetch after a taken redirect is wrong-path: one bubble.
                    state_d     = CTRL_RUN;
                    stall_cnt_d = '0;
                    wb_valid_d  = ex_valid_q;
                    ex_valid_d  = ~fire;
                end
            end
            default: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = CTRL_RUN;
                    ex_valid_d = 1'b1;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
        endcase
        stall_err_d = stall_err_q | (stall_cnt_d == STALL_LIMIT);
    end

    assign pc_sel        = pc_sel_s;
    assign pc_en         = ~freeze;
    assign ex_en         = ~freeze;
    assign wb_en         = ~freeze;
    assign ex_valid      = ex_valid_q;
    assign wb_valid      = wb_valid_q;
    assign redirect_fire = fire;
    assign stall_err     = stall_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic stall_evt;

    assign stall_evt = freeze & (state_q != CTRL_BOOT);

    pipe_perf_counter u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (fire),
        .count (bubble_cnt)
    );

    pipe_perf_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_evt),
        .count (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: cycle-level behavioural model plus directed literals.
// Build with PIPE_PERF_CNT_EN defined to also exercise the perf counters.
module tb_pipeline_ctrl;

    localparam int BB = 1;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_redirect = 1'b0;
    logic        mem_stall = 1'b0;
    logic [1:0]  pc_sel;
    logic        pc_en, ex_en, wb_en;
    logic        ex_valid, wb_valid, redirect_fire, stall_err;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] bubble_cnt, stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model: cycles since reset, slot valids, stall run length, sticky error
    int          m_cyc = 0;
    bit          m_exv = 1'b0;
    bit          m_wbv = 1'b0;
    int          m_stl = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_bub = '0;
    logic [31:0] m_stc = '0;

    pipeline_ctrl #(
        .BOOT_BUBBLES  (BB),
        .STALL_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_redirect   (ex_redirect),
        .mem_stall     (mem_stall),
        .pc_sel        (pc_sel),
        .pc_en         (pc_en),
        .ex_en         (ex_en),
        .wb_en         (wb_en),
        .ex_valid      (ex_valid),
        .wb_valid      (wb_valid),
        .redirect_fire (redirect_fire),
        .stall_err     (stall_err)
`ifdef PIPE_PERF_CNT_EN
        ,
        .bubble_cnt    (bubble_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc <= 0;
            m_exv <= 1'b0;
            m_wbv <= 1'b0;
            m_stl <= 0;
            m_err <= 1'b0;
            m_bub <= '0;
            m_stc <= '0;
        end else begin
            if (m_cyc < BB) begin
                if (m_cyc == BB - 1) m_exv <= 1'b1;
                m_cyc <= m_cyc + 1;
            end else if (!mem_stall) begin
                m_wbv <= m_exv;
                m_exv <= !(m_exv && ex_redirect);
                m_bub <= m_bub + 32'(m_exv && ex_redirect);
                m_stl <= 0;
            end else begin
                m_stl <= (m_stl < TO) ? m_stl + 1 : TO;
                if (m_stl + 1 >= TO) m_err <= 1'b1;
                m_stc <= m_stc + 32'd1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit boot, e_fire, e_en;
        logic [1:0] e_sel;
        if (!rst) begin
            boot   = (m_cyc < BB);
            e_fire = !boot && !mem_stall && m_exv && ex_redirect;
            e_en   = boot || !mem_stall;
            e_sel  = boot ? ((m_cyc == 0) ? 2'd2 : 2'd0) : (e_fire ? 2'd1 : 2'd0);
            chk("m_pc_sel", 32'(pc_sel), 32'(e_sel));
            chk("m_pc_en", 32'(pc_en), 32'(e_en));
            chk("m_ex_en", 32'(ex_en), 32'(e_en));
            chk("m_wb_en", 32'(wb_en), 32'(e_en));
            chk("m_fire", 32'(redirect_fire), 32'(e_fire));
            chk("m_ex_valid", 32'(ex_valid), 32'(m_exv));
            chk("m_wb_valid", 32'(wb_valid), 32'(m_wbv));
            chk("m_stall_err", 32'(stall_err), 32'(m_err));
`ifdef PIPE_PERF_CNT_EN
            chk("m_bubble_cnt", bubble_cnt, m_bub);
            chk("m_stall_cnt", stall_cnt, m_stc);
`endif
        end
    endtask

    task automatic cyc(input logic r, input logic s);
        @(posedge clk);
        #1;
        ex_redirect = r;
        mem_stall   = s;
        @(negedge clk);
        model_check();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc_sel"}, 32'(pc_sel), 32'd2);
        chk({tag, "_pc_en"}, 32'(pc_en), 32'd1);
        chk({tag, "_ex_en"}, 32'(ex_en), 32'd1);
        chk({tag, "_wb_en"}, 32'(wb_en), 32'd1);
        chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_fire"}, 32'(redirect_fire), 32'd0);
        chk({tag, "_stall_err"}, 32'(stall_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        // Boot cycle 0, with mem_stall asserted to show it is ignored in BOOT
        rst       = 1'b0;
        mem_stall = 1'b1;
        @(negedge clk);
        model_check();
        chk("boot0_pc_sel", 32'(pc_sel), 32'd2);
        chk("boot0_ex_valid", 32'(ex_valid), 32'd0);
        chk("boot0_pc_en", 32'(pc_en), 32'd1);

        cyc(0, 0);
        chk("c1_ex_valid", 32'(ex_valid), 32'd1);
        chk("c1_pc_sel", 32'(pc_sel), 32'd0);
        chk("c1_wb_valid", 32'(wb_valid), 32'd0);
        cyc(0, 0);
        chk("c2_wb_valid", 32'(wb_valid), 32'd1);

        // Single redirect: one bubble in EX, then one in WB
        cyc(1, 0);
        chk("rd_fire", 32'(redirect_fire), 32'd1);
        chk("rd_pc_sel", 32'(pc_sel), 32'd1);
        cyc(0, 0);
        chk("rd1_ex_valid", 32'(ex_valid), 32'd0);
        chk("rd1_wb_valid", 32'(wb_valid), 32'd1);
        cyc(0, 0);
        chk("rd2_ex_valid", 32'(ex_valid), 32'd1);
        chk("rd2_wb_valid", 32'(wb_valid), 32'd0);
        cyc(0, 0);
        chk("rd3_wb_valid", 32'(wb_valid), 32'd1);

        // Redirect on a bubble is ignored
        cyc(1, 0);
        chk("rd_b_fire", 32'(redirect_fire), 32'd1);
        cyc(1, 0);
        chk("bub_fire", 32'(redirect_fire), 32'd0);
        chk("bub_pc_sel", 32'(pc_sel), 32'd0);
        chk("bub_ex_valid", 32'(ex_valid), 32'd0);
        cyc(0, 0);
        chk("bub_next_ex_valid", 32'(ex_valid), 32'd1);

        // Stall wins over redirect; redirect fires on release
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1);
            chk("st_pc_en", 32'(pc_en), 32'd0);
            chk("st_ex_en", 32'(ex_en), 32'd0);
            chk("st_wb_en", 32'(wb_en), 32'd0);
            chk("st_fire", 32'(redirect_fire), 32'd0);
            chk("st_ex_valid", 32'(ex_valid), 32'd1);
        end
        cyc(1, 0);
        chk("rel_fire", 32'(redirect_fire), 32'd1);
        chk("rel_pc_sel", 32'(pc_sel), 32'd1);
        chk("rel_stall_err", 32'(stall_err), 32'd0);
        cyc(0, 0);
        chk("rel1_ex_valid", 32'(ex_valid), 32'd0);
        cyc(0, 0);

        // Watchdog: counter reaches 8 on the 8th stall cycle edge
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1);
            if (i == 7) chk("to7_stall_err", 32'(stall_err), 32'd0);
            if (i == 8) chk("to8_stall_err", 32'(stall_err), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0);
            chk("sticky_stall_err", 32'(stall_err), 32'd1);
        end
`ifdef PIPE_PERF_CNT_EN
        chk("lit_bubble_cnt", bubble_cnt, 32'd3);
        chk("lit_stall_cnt", stall_cnt, 32'd15);
`endif

        // Asynchronous reset in the third stall cycle
        for (int i = 0; i < 3; i++) cyc(0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
`ifdef PIPE_PERF_CNT_EN
        chk("midrst_bubble_cnt", bubble_cnt, 32'd0);
        chk("midrst_stall_cnt", stall_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst         = 1'b0;
        mem_stall   = 1'b0;
        ex_redirect = 1'b0;
        @(negedge clk);
        model_check();
        chk("reboot_pc_sel", 32'(pc_sel), 32'd2);
        chk("reboot_stall_err", 32'(stall_err), 32'd0);
        cyc(0, 0);
        chk("reboot_ex_valid", 32'(ex_valid), 32'd1);
        cyc(0, 0);
        cyc(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
